// File: rtl/ods_out_serializer_pkg.sv
// Shared constants and types for the ODS output serializer slice.
// Optional lane masking is enabled with ODS_OUT_SER_LANE_MASK_EN.
package ods_pkg;

  localparam int NUM_LANES         = 3;
  localparam int ODS_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    LANE1 = 2'd0,
    LANE2 = 2'd1,
    LANE3 = 2'd2
  } lane_e;

  // Element 0 is row 1, so {row3, row2, row1} packs naturally.
  typedef struct packed {
    logic [NUM_LANES-1:0][ODS_DEFAULT_WIDTH-1:0] word;
  } triple_t;

endpackage

// File: rtl/ods_out_serializer_if.sv
// Triple-in / word-out stream bundle for ods_out_serializer.
// The lane_mask member exists only when ODS_OUT_SER_LANE_MASK_EN is defined.
interface ods_out_serializer_if #(
  parameter int IO_DATA_WIDTH = 16
);

  logic [IO_DATA_WIDTH-1:0] in_1;
  logic [IO_DATA_WIDTH-1:0] in_2;
  logic [IO_DATA_WIDTH-1:0] in_3;
  logic                     in_valid;
  logic                     in_ready;
  logic [IO_DATA_WIDTH-1:0] out;
  logic                     out_valid;
  logic                     out_ready;
  logic [1:0]               out_lane;
  logic                     out_last;

`ifdef ODS_OUT_SER_LANE_MASK_EN
  logic [2:0]               lane_mask;

  modport master (
    output in_1, in_2, in_3, in_valid, lane_mask, out_ready,
    input  in_ready, out, out_valid, out_lane, out_last
  );

  modport slave (
    input  in_1, in_2, in_3, in_valid, lane_mask, out_ready,
    output in_ready, out, out_valid, out_lane, out_last
  );
`else
  modport master (
    output in_1, in_2, in_3, in_valid, out_ready,
    input  in_ready, out, out_valid, out_lane, out_last
  );

  modport slave (
    input  in_1, in_2, in_3, in_valid, out_ready,
    output in_ready, out, out_valid, out_lane, out_last
  );
`endif

endinterface

// File: rtl/ods_out_serializer_triple_fifo.sv
// Circular buffer of DEPTH triple entries with registered occupancy count.
// DEPTH need not be a power of two; pointers wrap explicitly.
module ods_triple_fifo #(
  parameter int ENTRY_WIDTH = 48,
  parameter int DEPTH       = 2
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   push,
  input  logic                   pop,
  input  logic [ENTRY_WIDTH-1:0] wr_data,
  output logic [ENTRY_WIDTH-1:0] rd_data,
  output logic                   full,
  output logic                   empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   push_ok;
  logic                   pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ods_out_serializer.sv
// Buffers row triples and emits them one word per transfer in lane order 1-2-3.
// Define ODS_OUT_SER_LANE_MASK_EN to store a per-triple lane mask that skips lanes.
module ods_out_serializer
  import ods_pkg::*;
#(
  parameter int IO_DATA_WIDTH = 16,
  parameter int DEPTH         = 2
) (
  input  logic                 clk,
  input  logic                 rst_in,
  ods_out_serializer_if.slave  bus
);

  localparam int W = IO_DATA_WIDTH;
`ifdef ODS_OUT_SER_LANE_MASK_EN
  localparam int ENTRY_W = NUM_LANES * W + NUM_LANES;
`else
  localparam int ENTRY_W = NUM_LANES * W;
`endif

  localparam logic [1:0] ST_LANE1 = LANE1;
  localparam logic [1:0] ST_LANE3 = LANE3;

  logic [ENTRY_W-1:0]              wr_data;
  logic [ENTRY_W-1:0]              rd_data;
  logic [NUM_LANES-1:0][W-1:0]     head_words;
  logic [NUM_LANES-1:0]            head_mask;
  logic                            full;
  logic                            empty;
  logic                            push;
  logic                            pop;
  logic                            fire;
  logic                            is_last;
  logic [1:0]                      lane_q;
  logic [1:0]                      cur_lane;
  logic [W-1:0]                    cur_word;

  assign head_words = rd_data[NUM_LANES*W-1:0];

`ifdef ODS_OUT_SER_LANE_MASK_EN
  // An all-zero mask carries no words, so such triples never occupy a slot.
  assign wr_data   = {bus.lane_mask, bus.in_3, bus.in_2, bus.in_1};
  assign head_mask = rd_data[ENTRY_W-1 -: NUM_LANES];
  assign push      = bus.in_valid && bus.in_ready && (bus.lane_mask != '0);
`else
  assign wr_data   = {bus.in_3, bus.in_2, bus.in_1};
  assign head_mask = '1;
  assign push      = bus.in_valid && bus.in_ready;
`endif

  ods_triple_fifo #(
    .ENTRY_WIDTH (ENTRY_W),
    .DEPTH       (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_in  (rst_in),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  // The presented lane is the first enabled lane at or above the lane state,
  // so skipping costs no extra cycles and stays stable while stalled.
  always_comb begin
    cur_lane = ST_LANE3;
    is_last  = 1'b1;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (head_mask[i] && (2'(i) >= lane_q)) begin
        cur_lane = 2'(i);
      end
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (head_mask[i] && (2'(i) > cur_lane)) begin
        is_last = 1'b0;
      end
    end
  end

  always_comb begin
    cur_word = '0;
    case (cur_lane)
      2'd0:    cur_word = head_words[0];
      2'd1:    cur_word = head_words[1];
      2'd2:    cur_word = head_words[2];
      default: cur_word = '0;
    endcase
  end

  assign bus.out_valid = !empty;
  assign bus.in_ready  = !rst_in && !full;
  assign bus.out       = bus.out_valid ? cur_word : '0;
  assign bus.out_lane  = bus.out_valid ? cur_lane : 2'd0;
  assign bus.out_last  = bus.out_valid && is_last;

  assign fire = bus.out_valid && bus.out_ready;
  assign pop  = fire && is_last;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      lane_q <= ST_LANE1;
    end else if (fire) begin
      lane_q <= is_last ? ST_LANE1 : cur_lane + 2'd1;
    end
  end

endmodule

// File: tb/tb_ods_out_serializer.sv
// Directed self-checking bench for ods_out_serializer (DEPTH = 2, 16-bit words).
// Mask cases run only when ODS_OUT_SER_LANE_MASK_EN is defined.
module tb_ods_out_serializer;

  logic clk = 1'b0;
  logic rst_in;
  int   errors = 0;
  int   checks = 0;

  ods_out_serializer_if #(.IO_DATA_WIDTH(16)) bus ();

  ods_out_serializer #(
    .IO_DATA_WIDTH (16),
    .DEPTH         (2)
  ) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic v,
                               input logic [2:0] mask);
    bus.in_1     = a;
    bus.in_2     = b;
    bus.in_3     = c;
    bus.in_valid = v;
`ifdef ODS_OUT_SER_LANE_MASK_EN
    bus.lane_mask = mask;
`endif
  endtask

  task automatic expect_word(input string tag, input logic [15:0] data,
                             input logic [1:0] lane, input logic last);
    checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, ".data"},  32'(bus.out), 32'(data));
    checkOutput({tag, ".lane"},  32'(bus.out_lane), 32'(lane));
    checkOutput({tag, ".last"},  32'(bus.out_last), 32'(last));
  endtask

  task automatic expect_idle(input string tag);
    checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, ".data"},  32'(bus.out), 32'd0);
    checkOutput({tag, ".lane"},  32'(bus.out_lane), 32'd0);
    checkOutput({tag, ".last"},  32'(bus.out_last), 32'd0);
  endtask

  logic [15:0] drain_data [6] = '{16'h0B01, 16'h0B02, 16'h0B03, 16'h0C01, 16'h0C02, 16'h0C03};

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_in        = 1'b1;
    bus.out_ready = 1'b0;
    applyStimulus(16'h0, 16'h0, 16'h0, 1'b0, 3'b111);
    #1;
    step();
    step();
    checkOutput("rst.in_ready", 32'(bus.in_ready), 32'd0);
    expect_idle("rst");
    rst_in = 1'b0;
    #1;
    checkOutput("post_rst.in_ready", 32'(bus.in_ready), 32'd1);

    // single triple streamed with consumer always ready
    bus.out_ready = 1'b1;
    applyStimulus(16'h0011, 16'h0022, 16'h0033, 1'b1, 3'b111);
    step();
    applyStimulus(16'h0, 16'h0, 16'h0, 1'b0, 3'b111);
    expect_word("t1.w1", 16'h0011, 2'd0, 1'b0);
    step();
    expect_word("t1.w2", 16'h0022, 2'd1, 1'b0);
    step();
    expect_word("t1.w3", 16'h0033, 2'd2, 1'b1);
    step();
    checkOutput("t1.done", 32'(bus.out_valid), 32'd0);

    // fill to full with consumer stalled
    bus.out_ready = 1'b0;
    applyStimulus(16'h0A01, 16'h0A02, 16'h0A03, 1'b1, 3'b111);
    step();
    checkOutput("fill.ready_a", 32'(bus.in_ready), 32'd1);
    applyStimulus(16'h0B01, 16'h0B02, 16'h0B03, 1'b1, 3'b111);
    step();
    checkOutput("fill.ready_b", 32'(bus.in_ready), 32'd0);
    expect_word("fill.a1", 16'h0A01, 2'd0, 1'b0);
    applyStimulus(16'h0C01, 16'h0C02, 16'h0C03, 1'b1, 3'b111);
    step();
    checkOutput("fill.ready_c", 32'(bus.in_ready), 32'd0);
    expect_word("fill.a1_held", 16'h0A01, 2'd0, 1'b0);

    // backpressure toggling within triple A
    bus.out_ready = 1'b1;
    step();
    expect_word("bp.a2", 16'h0A02, 2'd1, 1'b0);
    bus.out_ready = 1'b0;
    step();
    expect_word("bp.a2_held", 16'h0A02, 2'd1, 1'b0);
    bus.out_ready = 1'b1;
    step();
    expect_word("bp.a3", 16'h0A03, 2'd2, 1'b1);
    checkOutput("bp.full_ready", 32'(bus.in_ready), 32'd0);

    // pop of A3 while full must not accept C in the same cycle
    step();
    checkOutput("pp.ready_after_pop", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
    step();
    applyStimulus(16'h0, 16'h0, 16'h0, 1'b0, 3'b111);
    checkOutput("pp.ready_after_c", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expect_word($sformatf("drain%0d", i), drain_data[i], 2'(i % 3), (i % 3) == 2);
      step();
    end
    checkOutput("drain.done", 32'(bus.out_valid), 32'd0);

    // reset after D2 transferred discards D3 and E
    applyStimulus(16'h0D01, 16'h0D02, 16'h0D03, 1'b1, 3'b111);
    step();
    applyStimulus(16'h0E01, 16'h0E02, 16'h0E03, 1'b1, 3'b111);
    step();
    applyStimulus(16'h0, 16'h0, 16'h0, 1'b0, 3'b111);
    expect_word("mid.d2", 16'h0D02, 2'd1, 1'b0);
    step();
    expect_word("mid.d3", 16'h0D03, 2'd2, 1'b1);
    rst_in        = 1'b1;
    bus.out_ready = 1'b0;
    #1;
    checkOutput("mid.rst_ready", 32'(bus.in_ready), 32'd0);
    step();
    expect_idle("mid.rst");
    rst_in = 1'b0;
    applyStimulus(16'h0F01, 16'h0F02, 16'h0F03, 1'b1, 3'b111);
    step();
    applyStimulus(16'h0, 16'h0, 16'h0, 1'b0, 3'b111);
    expect_word("mid.f1", 16'h0F01, 2'd0, 1'b0);
    bus.out_ready = 1'b1;
    step();
    expect_word("mid.f2", 16'h0F02, 2'd1, 1'b0);
    step();
    expect_word("mid.f3", 16'h0F03, 2'd2, 1'b1);
    step();
    checkOutput("mid.done", 32'(bus.out_valid), 32'd0);

`ifdef ODS_OUT_SER_LANE_MASK_EN
    applyStimulus(16'd1, 16'd2, 16'd3, 1'b1, 3'b101);
    step();
    applyStimulus(16'h0, 16'h0, 16'h0, 1'b0, 3'b111);
    expect_word("m101.w1", 16'd1, 2'd0, 1'b0);
    step();
    expect_word("m101.w3", 16'd3, 2'd2, 1'b1);
    step();
    checkOutput("m101.done", 32'(bus.out_valid), 32'd0);
    applyStimulus(16'd7, 16'd8, 16'd9, 1'b1, 3'b000);
    #1;
    checkOutput("m000.ready", 32'(bus.in_ready), 32'd1);
    step();
    applyStimulus(16'h0, 16'h0, 16'h0, 1'b0, 3'b111);
    checkOutput("m000.valid", 32'(bus.out_valid), 32'd0);
    checkOutput("m000.ready_after", 32'(bus.in_ready), 32'd1);
    applyStimulus(16'd4, 16'd5, 16'd6, 1'b1, 3'b010);
    step();
    applyStimulus(16'h0, 16'h0, 16'h0, 1'b0, 3'b111);
    expect_word("m010.w2", 16'd5, 2'd1, 1'b1);
    step();
    checkOutput("m010.done", 32'(bus.out_valid), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
